// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_target_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_target_state_e;

  localparam logic [7:0] SPI_IDLE_WORD_DEFAULT = 8'hFF;

  // bit_cnt must be able to hold the value DATA_WIDTH.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a rise/fall pulse detector.
module spi_sync_edge
  import spi_target_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;
  assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, MSB-first shifters, valid/ready RX stream, one-entry TX holding register.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = SPI_IDLE_WORD_DEFAULT
) (
  input  logic                  io_clock,
  input  logic                  io_reset,
  input  logic                  spi_sclk,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  frame_active,
  output logic                  rx_overrun,
  output logic                  tx_underrun
);

  localparam int              CNT_W    = bit_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Streams: rx moves on rx_valid && rx_ready; rx_valid never drops without a
  // transfer. tx_data is taken on tx_valid && tx_ready (holding register empty).

  spi_target_state_e r_state;
  spi_target_state_e w_state_next;
  logic              w_start;
  logic              w_end;

  logic w_sclk_rise, w_sclk_fall;
  logic w_ss_rise, w_ss_fall;
  logic w_mosi;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic [DATA_WIDTH-1:0] r_shift_tx;
  logic [DATA_WIDTH-2:0] r_shift_rx;
  logic [DATA_WIDTH-1:0] w_rx_word;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_word_done;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_overrun;
  logic                  r_tx_underrun;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;

  logic w_rx_edge, w_tx_edge, w_load, w_tx_accept;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .i_clk   (io_clock),
    .i_rst   (io_reset),
    .i_async (spi_sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // ss resets low so a select held low through reset gives no falling edge;
  // only a fresh high-to-low transition opens a frame.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_ss_sync (
    .i_clk   (io_clock),
    .i_rst   (io_reset),
    .i_async (spi_ss),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_next = SHIFT;
          w_start      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_state_next = IDLE;
          w_end        = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // An sclk edge coinciding with the closing ss edge belongs to no word.
  assign w_rx_edge   = (r_state == SHIFT) && w_sclk_rise && !w_ss_rise;
  assign w_tx_edge   = (r_state == SHIFT) && w_sclk_fall && !w_ss_rise;
  assign w_load      = w_start || (w_tx_edge && r_word_done);
  assign w_tx_accept = tx_valid && !r_hold_full;
  assign w_rx_word   = {r_shift_rx, w_mosi};

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_shift_tx    <= '0;
      r_shift_rx    <= '0;
      r_bit_cnt     <= '0;
      r_word_done   <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
    end else begin
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;

      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      if (w_tx_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        if (r_hold_full) begin
          r_shift_tx <= r_hold;
        end else begin
          r_shift_tx    <= IDLE_WORD;
          r_tx_underrun <= 1'b1;
        end
      end else if (w_tx_edge) begin
        r_shift_tx <= {r_shift_tx[DATA_WIDTH-2:0], 1'b0};
      end

      if (w_tx_edge) r_word_done <= 1'b0;

      if (w_end) begin
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
      end else if (w_rx_edge) begin
        r_shift_rx <= w_rx_word[DATA_WIDTH-2:0];
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt   <= '0;
          r_word_done <= 1'b1;
          if (!r_rx_valid || rx_ready) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_overrun <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign spi_miso     = r_shift_tx[DATA_WIDTH-1];
  assign frame_active = (r_state == SHIFT);
  assign spi_miso_oe  = frame_active;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign tx_ready     = !r_hold_full;
  assign rx_overrun   = r_rx_overrun;
  assign tx_underrun  = r_tx_underrun;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI master, RX scoreboard queue, pulse counters.
module tb_spi_target;

  localparam int W     = 8;
  localparam int HALF  = 8;
  localparam int SETUP = 8;

  logic         io_clock = 1'b0;
  logic         io_reset = 1'b1;
  logic         spi_sclk = 1'b0;
  logic         spi_ss   = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         rx_ready = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data  = '0;

  logic         spi_miso;
  logic         spi_miso_oe;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         tx_ready;
  logic         frame_active;
  logic         rx_overrun;
  logic         tx_underrun;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_rxv  = 0;
  int cnt_ovr  = 0;
  int cnt_udr  = 0;

  logic [W-1:0] exp_q[$];

  spi_target dut (
    .io_clock     (io_clock),
    .io_reset     (io_reset),
    .spi_sclk     (spi_sclk),
    .spi_ss       (spi_ss),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .frame_active (frame_active),
    .rx_overrun   (rx_overrun),
    .tx_underrun  (tx_underrun)
  );

  // Clock and watchdog
  always #5 io_clock = ~io_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts pulses and pops the scoreboard on each RX transfer.
  always begin
    @(negedge io_clock);
    #1;
    if (!io_reset) begin
      if (rx_valid) cnt_rxv++;
      if (rx_overrun) cnt_ovr++;
      if (tx_underrun) cnt_udr++;
      if (rx_valid && rx_ready) begin
        check("rx_word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("rx_data_order", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge io_clock);
  endtask

  task automatic tx_push(input logic [W-1:0] d);
    int t = 0;
    while (!tx_ready && t < 200) begin
      wait_cyc(1);
      t++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    wait_cyc(SETUP);
  endtask

  // Sends nbits MSB first; with last set, ss rises together with the final sclk fall.
  task automatic spi_xfer(input logic [W-1:0] mo, input int nbits, input bit last,
                          output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[W-1-i];
      wait_cyc(HALF);
      mi = {mi[W-2:0], spi_miso};
      spi_sclk = 1'b1;
      wait_cyc(HALF);
      spi_sclk = 1'b0;
      if (last && i == nbits - 1) spi_ss = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      wait_cyc(1);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},        32'(spi_miso),     32'd0);
    check({tag, "_miso_oe"},     32'(spi_miso_oe),  32'd0);
    check({tag, "_rx_data"},     32'(rx_data),      32'd0);
    check({tag, "_rx_valid"},    32'(rx_valid),     32'd0);
    check({tag, "_tx_ready"},    32'(tx_ready),     32'd1);
    check({tag, "_frame"},       32'(frame_active), 32'd0);
    check({tag, "_rx_overrun"},  32'(rx_overrun),   32'd0);
    check({tag, "_tx_underrun"}, 32'(tx_underrun),  32'd0);
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] got2;
    int rxv0, ovr0, udr0;

    // Reset
    wait_cyc(4);
    check_reset_outputs("reset");
    io_reset = 1'b0;
    wait_cyc(4);

    // Single frame: A5 out, 3C in
    rx_ready = 1'b1;
    tx_push(8'hA5);
    exp_q.push_back(8'h3C);
    rxv0 = cnt_rxv; udr0 = cnt_udr;
    ss_begin();
    check("single_frame_active", 32'(frame_active), 32'd1);
    check("single_miso_oe",      32'(spi_miso_oe),  32'd1);
    spi_xfer(8'h3C, 8, 1'b1, got);
    wait_cyc(12);
    check("single_miso_word",   32'(got),            32'hA5);
    drain("single_rx_drain");
    check("single_rx_data",     32'(rx_data),        32'h3C);
    check("single_rxv_cycles",  32'(cnt_rxv - rxv0), 32'd1);
    check("single_no_underrun", 32'(cnt_udr - udr0), 32'd0);
    check("single_frame_end",   32'(frame_active),   32'd0);
    check("single_oe_end",      32'(spi_miso_oe),    32'd0);

    // Back-to-back words, second tx word supplied mid-frame
    tx_push(8'h11);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    udr0 = cnt_udr;
    ss_begin();
    tx_push(8'h22);
    spi_xfer(8'h01, 8, 1'b0, got);
    spi_xfer(8'h02, 8, 1'b1, got2);
    wait_cyc(12);
    check("b2b_miso_word0",  32'(got),            32'h11);
    check("b2b_miso_word1",  32'(got2),           32'h22);
    drain("b2b_rx_drain");
    check("b2b_no_underrun", 32'(cnt_udr - udr0), 32'd0);

    // Underrun: nothing held
    exp_q.push_back(8'h5A);
    udr0 = cnt_udr;
    ss_begin();
    spi_xfer(8'h5A, 8, 1'b1, got);
    wait_cyc(12);
    check("udr_miso_word", 32'(got),            32'hFF);
    check("udr_pulses",    32'(cnt_udr - udr0), 32'd1);
    drain("udr_rx_drain");

    // Overrun: consumer stalled across two words
    rx_ready = 1'b0;
    exp_q.push_back(8'hAA);
    ovr0 = cnt_ovr;
    ss_begin();
    spi_xfer(8'hAA, 8, 1'b0, got);
    spi_xfer(8'h55, 8, 1'b1, got);
    wait_cyc(12);
    check("ovr_rx_data",  32'(rx_data),          32'hAA);
    check("ovr_rx_valid", 32'(rx_valid),         32'd1);
    check("ovr_pulses",   32'(cnt_ovr - ovr0),   32'd1);
    rx_ready = 1'b1;
    drain("ovr_rx_drain");
    wait_cyc(2);
    check("ovr_valid_clear", 32'(rx_valid), 32'd0);

    // Aborted word, then a clean frame
    rxv0 = cnt_rxv; ovr0 = cnt_ovr;
    ss_begin();
    spi_xfer(8'hF0, 5, 1'b1, got);
    wait_cyc(12);
    check("abort_no_rxv",     32'(cnt_rxv - rxv0), 32'd0);
    check("abort_no_overrun", 32'(cnt_ovr - ovr0), 32'd0);
    exp_q.push_back(8'h0F);
    ss_begin();
    spi_xfer(8'h0F, 8, 1'b1, got);
    wait_cyc(12);
    drain("abort_rx_drain");
    check("abort_next_rx_data", 32'(rx_data), 32'h0F);

    // Reset mid-frame
    tx_push(8'h77);
    ss_begin();
    spi_xfer(8'hC3, 3, 1'b0, got);
    check("rst_mid_frame_active", 32'(frame_active), 32'd1);
    io_reset = 1'b1;
    wait_cyc(1);
    check_reset_outputs("rst_mid");
    io_reset = 1'b0;
    wait_cyc(8);
    check("rst_no_reentry", 32'(frame_active), 32'd0);
    spi_ss = 1'b1;
    wait_cyc(8);
    exp_q.push_back(8'h96);
    ss_begin();
    spi_xfer(8'h96, 8, 1'b1, got);
    wait_cyc(12);
    check("rst_fresh_miso", 32'(got), 32'hFF);
    drain("rst_fresh_drain");
    check("rst_fresh_rx_data", 32'(rx_data), 32'h96);

    // Report
    wait_cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
